// File: rtl/audio_pdm_out.sv
`default_nettype none
// ============================================================================
// audio_pdm_out : sample FIFO feeding a first-order sigma-delta PDM modulator
// Revision      : 1.0
// ============================================================================
module audio_pdm_out #(
    parameter int BITDEPTH   = 14,
    parameter int SAMPLE_DIV = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [BITDEPTH-1:0]           in_sample,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          sample_tick,
    output logic                          underrun,
    input  logic                          underrun_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          pdm_out
);

    localparam int CW = $clog2(SAMPLE_DIV);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]       CNT_MAX = CW'(SAMPLE_DIV - 1);
    localparam logic [BITDEPTH-1:0] CUR_RST = BITDEPTH'((1 << (BITDEPTH - 1)) - 1);

    logic [BITDEPTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]       level_q, level_d;
    logic [CW-1:0]       cnt_q;
    logic                tick_q;
    logic [BITDEPTH-1:0] cur_q;
    logic [BITDEPTH:0]   acc_q, acc_d;
    logic                underrun_q;
    logic                push, pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // in_ready looks only at the registered level so a same-cycle pop cannot open it
    assign in_ready    = (level_q < LW'(FIFO_DEPTH));
    assign sample_tick = tick_q & enable;
    assign push        = in_valid & in_ready;
    assign pop         = sample_tick & (level_q != '0);
    assign fifo_level  = level_q;
    assign underrun    = underrun_q;
    assign pdm_out     = acc_q[BITDEPTH];

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    assign acc_d = {1'b0, acc_q[BITDEPTH-1:0]} + {1'b0, cur_q};

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_sample;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            acc_q  <= '0;
        end else if (!enable) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            acc_q  <= '0;
        end else begin
            cnt_q  <= (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
            tick_q <= (cnt_q == CNT_MAX);
            acc_q  <= acc_d;
        end
    end

    // A set in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q      <= CUR_RST;
            underrun_q <= 1'b0;
        end else begin
            if (pop) begin
                cur_q <= mem_q[rd_ptr_q];
            end
            if (sample_tick && (level_q == '0)) begin
                underrun_q <= 1'b1;
            end else if (underrun_clr) begin
                underrun_q <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_audio_pdm_out.sv
`default_nettype none
// ============================================================================
// tb_audio_pdm_out : scoreboard bench for audio_pdm_out (14-bit, div 16, depth 4)
// Revision         : 1.0
// ============================================================================
module tb_audio_pdm_out;

    localparam int BD    = 14;
    localparam int DIV   = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          enable = 1'b0;
    logic [BD-1:0] in_sample = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          sample_tick;
    logic          underrun;
    logic          underrun_clr = 1'b0;
    logic [2:0]    fifo_level;
    logic          pdm_out;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    // Reference model state; the queue holds the samples expected to pop, in order
    logic [BD-1:0] sbq [$];
    int            m_cnt   = 0;
    bit            m_tick  = 1'b0;
    logic [BD:0]   m_acc   = '0;
    logic [BD-1:0] m_cur   = 14'd8191;
    bit            m_under = 1'b0;

    audio_pdm_out #(
        .BITDEPTH   (BD),
        .SAMPLE_DIV (DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .in_sample    (in_sample),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .sample_tick  (sample_tick),
        .underrun     (underrun),
        .underrun_clr (underrun_clr),
        .fifo_level   (fifo_level),
        .pdm_out      (pdm_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt   <= 0;
            m_tick  <= 1'b0;
            m_acc   <= '0;
            m_cur   <= 14'd8191;
            m_under <= 1'b0;
            sbq.delete();
        end else begin
            automatic bit tk  = m_tick && enable;
            automatic bit emp = (sbq.size() == 0);
            automatic bit psh = in_valid && (sbq.size() < DEPTH);
            if (enable) begin
                m_cnt  <= (m_cnt == DIV - 1) ? 0 : m_cnt + 1;
                m_tick <= (m_cnt == DIV - 1);
                m_acc  <= {1'b0, m_acc[BD-1:0]} + {1'b0, m_cur};
            end else begin
                m_cnt  <= 0;
                m_tick <= 1'b0;
                m_acc  <= '0;
            end
            if (tk && !emp) begin
                m_cur <= sbq[0];
                void'(sbq.pop_front());
            end
            if (tk && emp) begin
                m_under <= 1'b1;
            end else if (underrun_clr) begin
                m_under <= 1'b0;
            end
            if (psh) begin
                sbq.push_back(in_sample);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check_eq("pdm",      pdm_out,     m_acc[BD]);
            check_eq("tick",     sample_tick, m_tick && enable);
            check_eq("level",    fifo_level,  sbq.size());
            check_eq("in_ready", in_ready,    sbq.size() < DEPTH);
            check_eq("underrun", underrun,    m_under);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!sample_tick && n < 3 * DIV);
        check_eq("tick_seen", sample_tick, 1);
    endtask

    initial begin
        logic [BD-1:0] vals [5];
        logic [5:0]    pv;
        int            n;
        int            ones;
        vals = '{14'd8192, 14'd0, 14'd16383, 14'd12000, 14'd5};

        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_level",    fifo_level,  0);
        check_eq("rst_in_ready", in_ready,    1);
        check_eq("rst_pdm",      pdm_out,     0);
        check_eq("rst_tick",     sample_tick, 0);
        check_eq("rst_underrun", underrun,    0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        step();
        check_eq("rel_level",    fifo_level, 0);
        check_eq("rel_in_ready", in_ready,   1);
        check_eq("rel_pdm",      pdm_out,    0);
        check_eq("rel_underrun", underrun,   0);

        // Fill with enable low; the fifth offer must be refused
        for (int i = 0; i < 5; i++) begin
            in_sample = vals[i];
            in_valid  = 1'b1;
            @(negedge clk);
            check_eq("fill_ready", in_ready, (i < DEPTH) ? 1 : 0);
            step();
        end
        in_valid = 1'b0;
        check_eq("fill_level", fifo_level, 4);

        enable = 1'b1;
        wait_tick(n);
        check_eq("first_tick_cycles", n, DIV);
        step();
        for (int k = 0; k < 6; k++) begin
            step();
            pv[k] = pdm_out;
        end
        for (int k = 0; k < 5; k++) begin
            check_eq("half_alternate", pv[k] ^ pv[k+1], 1);
        end

        wait_tick(n);
        step();
        ones = 0;
        for (int k = 0; k < DIV - 2; k++) begin
            step();
            ones += int'(pdm_out);
        end
        check_eq("zero_ones", ones, 0);

        wait_tick(n);
        step();
        ones = 0;
        for (int k = 0; k < DIV - 2; k++) begin
            step();
            ones += int'(pdm_out);
        end
        check_eq("full_ones_ge13", ones >= DIV - 3, 1);

        wait_tick(n);
        wait_tick(n);
        check_eq("period_cycles", n, DIV);
        step();
        check_eq("underrun_set", underrun, 1);

        // Mid-period reset with three samples queued
        enable = 1'b0;
        step();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_sample = 14'(1000 * (i + 1));
            step();
        end
        in_valid = 1'b0;
        check_eq("lvl3", fifo_level, 3);
        enable = 1'b1;
        repeat (7) step();
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_level",    fifo_level,  0);
        check_eq("mid_rst_in_ready", in_ready,    1);
        check_eq("mid_rst_pdm",      pdm_out,     0);
        check_eq("mid_rst_tick",     sample_tick, 0);
        check_eq("mid_rst_underrun", underrun,    0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_tick(n);
        check_eq("post_rst_tick_cycles", n, DIV);
        step();
        check_eq("empty_underrun", underrun, 1);

        wait_tick(n);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        check_eq("set_beats_clr", underrun, 1);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        check_eq("clr_works", underrun, 0);

        enable = 1'b0;
        repeat (3) step();
        check_eq("dis_pdm",  pdm_out,     0);
        check_eq("dis_tick", sample_tick, 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
